// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the load/store path: access-size encodings and the
// data memory controller state type.
package packages;

   localparam logic [2:0] LB_SB = 3'b000;
   localparam logic [2:0] LH_SH = 3'b001;
   localparam logic [2:0] LW_SW = 3'b010;
   localparam logic [2:0] LBU   = 3'b100;
   localparam logic [2:0] LHU   = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

   function automatic logic size_legal(input logic [2:0] size);
      return size inside {LB_SB, LH_SH, LW_SW, LBU, LHU};
   endfunction

endpackage

// File: rtl/data_memory_ctrl_lsu_align.sv
// Byte-lane steering between right-aligned register data and a 32-bit memory
// word: store strobes and replication, load lane select and extension.
module lsu_align
   import packages::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  strobe,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        misalign
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign rbyte = rword[{addr_lo, 3'b000} +: 8];
   assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

   // NOTE: every output gets a default before the case so no path leaves one
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      strobe   = 4'b0000;
      wword    = wdata;
      rdata    = '0;
      misalign = 1'b0;
      case (size)
         LB_SB, LBU: begin
            strobe = 4'b0001 << addr_lo;
            wword  = {4{wdata[7:0]}};
            rdata  = size[2] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
         end
         LH_SH, LHU: begin
            misalign = addr_lo[0];
            strobe   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wword    = {2{wdata[15:0]}};
            rdata    = size[2] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
         end
         LW_SW: begin
            misalign = (addr_lo != 2'b00);
            strobe   = 4'b1111;
            rdata    = rword;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory behind the LSU: one outstanding request, byte-lane
// stores, configurable read latency and an error response for bad requests.
module data_memory_ctrl
   import packages::*;
#(
   parameter int DEPTH_WORDS  = 256,
   parameter int READ_LATENCY = 1,
   parameter int PROTECT_ZERO = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = $clog2(READ_LATENCY + 1);

   logic [31:0]      mem [DEPTH_WORDS];
   dmem_state_e      state;
   logic [CNT_W-1:0] count;

   logic [IDX_W-1:0] word_idx;
   logic             in_range;
   logic             protect_hit;
   logic             req_err;
   logic             accept;
   logic [3:0]       strobe;
   logic [31:0]      wword;
   logic [31:0]      ext_rdata;
   logic             misalign;

   assign word_idx    = req_addr[IDX_W+1:2];
   assign in_range    = (req_addr[31:IDX_W+2] == '0);
   assign protect_hit = (PROTECT_ZERO != 0) && req_we && (req_addr[31:2] == '0);
   assign req_err     = misalign || !in_range || protect_hit || !size_legal(req_size);

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;

   lsu_align u_align (
      .size     (req_size),
      .addr_lo  (req_addr[1:0]),
      .wdata    (req_wdata),
      .rword    (mem[word_idx]),
      .strobe   (strobe),
      .wword    (wword),
      .rdata    (ext_rdata),
      .misalign (misalign)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees pre-edge values regardless of statement order.
   // NOTE: the memory is cleared by reset, which rules out a RAM macro and
   // maps it to resettable flops.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_err   <= req_err;
                  // Load data is captured now so later stores cannot alter it.
                  rsp_rdata <= (req_we || req_err) ? 32'b0 : ext_rdata;
                  if (req_we && !req_err) begin
                     for (int l = 0; l < 4; l++)
                        if (strobe[l]) mem[word_idx][8*l +: 8] <= wword[8*l +: 8];
                  end
                  if (!req_we && !req_err && READ_LATENCY > 1) begin
                     state <= WAIT;
                     count <= CNT_W'(READ_LATENCY - 1);
                  end else begin
                     state <= RESP;
                  end
               end
            end
            WAIT: begin
               count <= count - 1'b1;
               if (count == CNT_W'(1)) state <= RESP;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomised and directed bench for data_memory_ctrl across three parameter
// sets, checked against a byte-addressed reference model.
module tb_data_memory_ctrl;
   import packages::*;

   typedef struct packed {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } op_t;

   // Instance 0: RL=1, protected; 1: RL=3, unprotected; 2: RL=4, protected.
   int rl_of [3] = '{1, 3, 4};
   bit pz_of [3] = '{1'b1, 1'b0, 1'b1};

   logic        clock = 1'b0;
   logic        reset     [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_we    [3];
   logic [2:0]  req_size  [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];

   logic [7:0]  mmem [3][1024];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   data_memory_ctrl #(.DEPTH_WORDS(256), .READ_LATENCY(1), .PROTECT_ZERO(1)) dut0 (
      .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   data_memory_ctrl #(.DEPTH_WORDS(256), .READ_LATENCY(3), .PROTECT_ZERO(0)) dut1 (
      .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   data_memory_ctrl #(.DEPTH_WORDS(256), .READ_LATENCY(4), .PROTECT_ZERO(1)) dut2 (
      .clock(clock), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_size(req_size[2]), .req_addr(req_addr[2]),
      .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
      .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

   // Reference model: byte-addressed little-endian memory, rules applied directly.
   function automatic void model_op(input int d, input op_t op, output logic e_err,
                                    output logic [31:0] e_rd, output int e_lat);
      int n;
      logic [31:0] v;
      n = (op.size[1:0] == 2'd0) ? 1 : (op.size[1:0] == 2'd1) ? 2 : 4;
      e_err = !(op.size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
              (op.addr % n != 0) || (op.addr >= 32'd1024) ||
              (op.we && pz_of[d] && op.addr < 32'd4);
      e_rd  = '0;
      e_lat = (op.we || e_err) ? 1 : rl_of[d];
      if (!e_err) begin
         if (op.we) begin
            for (int i = 0; i < n; i++) mmem[d][op.addr + i] = op.wdata[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mmem[d][op.addr + i];
            if (!op.size[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!op.size[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
            e_rd = v;
         end
      end
   endfunction

   // Drives one request, measures cycles to rsp_valid, then consumes the response.
   task automatic run_req(input int d, input op_t op, input int hold, output logic o_err,
                          output logic [31:0] o_rd, output int o_lat);
      int waited;
      @(negedge clock);
      req_we[d] = op.we; req_size[d] = op.size; req_addr[d] = op.addr;
      req_wdata[d] = op.wdata; req_valid[d] = 1'b1;
      waited = 0;
      while (req_ready[d] !== 1'b1 && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      @(posedge clock);
      #1 req_valid[d] = 1'b0;
      o_lat = 0;
      do begin
         @(negedge clock);
         o_lat++;
      end while (rsp_valid[d] !== 1'b1 && o_lat < 20);
      o_err = rsp_err[d];
      o_rd  = rsp_rdata[d];
      repeat (hold) @(negedge clock);
      rsp_ready[d] = 1'b1;
      @(posedge clock);
      #1 rsp_ready[d] = 1'b0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset d=%0d: got ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 00000000",
                     d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
         end
      end
   endtask

   task automatic test_word();
      op_t ops [2] = '{'{1'b1, LW_SW, 32'h10, 32'hDEADBEEF}, '{1'b0, LW_SW, 32'h10, 32'h0}};
      logic e_err, o_err; logic [31:0] e_rd, o_rd; int e_lat, o_lat;
      for (int d = 0; d < 2; d++) begin
         foreach (ops[i]) begin
            model_op(d, ops[i], e_err, e_rd, e_lat);
            run_req(d, ops[i], 0, o_err, o_rd, o_lat);
            vectors++;
            if ({o_err, o_rd, o_lat} !== {e_err, e_rd, e_lat}) begin
               miscompares++;
               $display("FAIL word d=%0d op%0d: got err=%b rdata=%h lat=%0d, expected err=%b rdata=%h lat=%0d",
                        d, i, o_err, o_rd, o_lat, e_err, e_rd, e_lat);
            end
         end
      end
   endtask

   task automatic test_extension();
      op_t ops [8] = '{
         '{1'b1, LB_SB, 32'h21, 32'h00000080}, '{1'b0, LB_SB, 32'h21, 32'h0},
         '{1'b0, LBU,   32'h21, 32'h0},        '{1'b1, LH_SH, 32'h22, 32'h00008001},
         '{1'b0, LH_SH, 32'h22, 32'h0},        '{1'b0, LHU,   32'h22, 32'h0},
         '{1'b0, LW_SW, 32'h20, 32'h0},        '{1'b0, LBU,   32'h20, 32'h0}};
      logic e_err, o_err; logic [31:0] e_rd, o_rd; int e_lat, o_lat;
      foreach (ops[i]) begin
         model_op(0, ops[i], e_err, e_rd, e_lat);
         run_req(0, ops[i], 0, o_err, o_rd, o_lat);
         vectors++;
         if ({o_err, o_rd, o_lat} !== {e_err, e_rd, e_lat}) begin
            miscompares++;
            $display("FAIL extension op%0d: got err=%b rdata=%h lat=%0d, expected err=%b rdata=%h lat=%0d",
                     i, o_err, o_rd, o_lat, e_err, e_rd, e_lat);
         end
      end
   endtask

   task automatic test_errors();
      op_t ops [7] = '{
         '{1'b0, LW_SW,  32'h12,  32'h0}, '{1'b1, LH_SH, 32'h23, 32'h00008001},
         '{1'b0, LW_SW,  32'h20,  32'h0}, '{1'b0, LW_SW, 32'h400, 32'h0},
         '{1'b0, 3'b011, 32'h20,  32'h0}, '{1'b1, LW_SW, 32'h401, 32'h11111111},
         '{1'b0, LHU,    32'h3FE, 32'h0}};
      logic e_err, o_err; logic [31:0] e_rd, o_rd; int e_lat, o_lat;
      for (int d = 0; d < 2; d++) begin
         foreach (ops[i]) begin
            model_op(d, ops[i], e_err, e_rd, e_lat);
            run_req(d, ops[i], 0, o_err, o_rd, o_lat);
            vectors++;
            if ({o_err, o_rd, o_lat} !== {e_err, e_rd, e_lat}) begin
               miscompares++;
               $display("FAIL errors d=%0d op%0d: got err=%b rdata=%h lat=%0d, expected err=%b rdata=%h lat=%0d",
                        d, i, o_err, o_rd, o_lat, e_err, e_rd, e_lat);
            end
         end
      end
   endtask

   task automatic test_protect();
      op_t ops [2] = '{'{1'b1, LW_SW, 32'h0, 32'h12345678}, '{1'b0, LW_SW, 32'h0, 32'h0}};
      logic e_err, o_err; logic [31:0] e_rd, o_rd; int e_lat, o_lat;
      for (int d = 0; d < 2; d++) begin
         foreach (ops[i]) begin
            model_op(d, ops[i], e_err, e_rd, e_lat);
            run_req(d, ops[i], 0, o_err, o_rd, o_lat);
            vectors++;
            if ({o_err, o_rd, o_lat} !== {e_err, e_rd, e_lat}) begin
               miscompares++;
               $display("FAIL protect d=%0d op%0d: got err=%b rdata=%h lat=%0d, expected err=%b rdata=%h lat=%0d",
                        d, i, o_err, o_rd, o_lat, e_err, e_rd, e_lat);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      op_t ld  = '{1'b0, LW_SW, 32'h10, 32'h0};
      op_t chk = '{1'b0, LW_SW, 32'h30, 32'h0};
      logic e_err, o_err; logic [31:0] e_rd, o_rd; int e_lat, o_lat, waited;
      model_op(1, ld, e_err, e_rd, e_lat);
      @(negedge clock);
      req_we[1] = 1'b0; req_size[1] = LW_SW; req_addr[1] = 32'h10; req_valid[1] = 1'b1;
      @(posedge clock);
      #1 req_valid[1] = 1'b0;
      waited = 0;
      do begin
         @(negedge clock);
         waited++;
      end while (rsp_valid[1] !== 1'b1 && waited < 20);
      // A store is offered while the response is stalled; it must not be taken.
      req_we[1] = 1'b1; req_size[1] = LW_SW; req_addr[1] = 32'h30;
      req_wdata[1] = 32'hAAAA5555; req_valid[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         vectors++;
         if ({rsp_valid[1], req_ready[1], rsp_err[1], rsp_rdata[1]} !== {1'b1, 1'b0, 1'b0, e_rd}) begin
            miscompares++;
            $display("FAIL backpressure cycle%0d: got valid=%b ready=%b err=%b rdata=%h, expected 1 0 0 %h",
                     c, rsp_valid[1], req_ready[1], rsp_err[1], rsp_rdata[1], e_rd);
         end
      end
      req_valid[1] = 1'b0;
      rsp_ready[1] = 1'b1;
      @(posedge clock);
      #1 rsp_ready[1] = 1'b0;
      @(negedge clock);
      vectors++;
      if ({rsp_valid[1], req_ready[1]} !== 2'b01) begin
         miscompares++;
         $display("FAIL backpressure release: got valid=%b ready=%b, expected 0 1", rsp_valid[1], req_ready[1]);
      end
      model_op(1, chk, e_err, e_rd, e_lat);
      run_req(1, chk, 0, o_err, o_rd, o_lat);
      vectors++;
      if ({o_err, o_rd, o_lat} !== {e_err, e_rd, e_lat}) begin
         miscompares++;
         $display("FAIL backpressure untaken store: got err=%b rdata=%h lat=%0d, expected err=%b rdata=%h lat=%0d",
                  o_err, o_rd, o_lat, e_err, e_rd, e_lat);
      end
   endtask

   task automatic test_random();
      op_t op;
      logic e_err, o_err; logic [31:0] e_rd, o_rd; int e_lat, o_lat, r;
      for (int n = 0; n < 150; n++) begin
         automatic int d = n % 3;
         op.we = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0, 1:    op.size = LB_SB;
            2:       op.size = LBU;
            3, 4:    op.size = LH_SH;
            5:       op.size = LHU;
            6, 7, 8: op.size = LW_SW;
            default: op.size = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'b111;
         endcase
         r = $urandom_range(0, 15);
         if (r == 0)      op.addr = 32'h400 + $urandom_range(0, 15);
         else if (r == 1) op.addr = $urandom;
         else             op.addr = $urandom_range(0, 63);
         if ($urandom_range(0, 3) != 0) begin
            if (op.size[1:0] == 2'd1) op.addr[0] = 1'b0;
            if (op.size[1:0] == 2'd2) op.addr[1:0] = 2'b00;
         end
         op.wdata = $urandom;
         model_op(d, op, e_err, e_rd, e_lat);
         run_req(d, op, $urandom_range(0, 2), o_err, o_rd, o_lat);
         vectors++;
         if ({o_err, o_rd, o_lat} !== {e_err, e_rd, e_lat}) begin
            miscompares++;
            $display("FAIL random n=%0d d=%0d we=%b size=%b addr=%h: got err=%b rdata=%h lat=%0d, expected err=%b rdata=%h lat=%0d",
                     n, d, op.we, op.size, op.addr, o_err, o_rd, o_lat, e_err, e_rd, e_lat);
         end
      end
   endtask

   task automatic test_reset_mid();
      op_t st = '{1'b1, LW_SW, 32'h44, 32'hCAFEF00D};
      op_t ld = '{1'b0, LW_SW, 32'h44, 32'h0};
      logic e_err, o_err; logic [31:0] e_rd, o_rd; int e_lat, o_lat;
      model_op(2, st, e_err, e_rd, e_lat);
      run_req(2, st, 0, o_err, o_rd, o_lat);
      vectors++;
      if ({o_err, o_lat} !== {e_err, e_lat}) begin
         miscompares++;
         $display("FAIL reset_mid store: got err=%b lat=%0d, expected err=%b lat=%0d", o_err, o_lat, e_err, e_lat);
      end
      @(negedge clock);
      req_we[2] = 1'b0; req_size[2] = LW_SW; req_addr[2] = 32'h44; req_valid[2] = 1'b1;
      @(posedge clock);
      #1 req_valid[2] = 1'b0;
      @(negedge clock);
      reset[2] = 1'b1;
      @(negedge clock);
      reset[2] = 1'b0;
      for (int i = 0; i < 1024; i++) mmem[2][i] = 8'h00;
      vectors++;
      if ({req_ready[2], rsp_valid[2]} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_mid after reset: got ready=%b valid=%b, expected 1 0", req_ready[2], rsp_valid[2]);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         vectors++;
         if (rsp_valid[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid no response cycle%0d: got valid=%b, expected 0", c, rsp_valid[2]);
         end
      end
      model_op(2, ld, e_err, e_rd, e_lat);
      run_req(2, ld, 0, o_err, o_rd, o_lat);
      vectors++;
      if ({o_err, o_rd, o_lat} !== {e_err, e_rd, e_lat}) begin
         miscompares++;
         $display("FAIL reset_mid readback: got err=%b rdata=%h lat=%0d, expected err=%b rdata=%h lat=%0d",
                  o_err, o_rd, o_lat, e_err, e_rd, e_lat);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = LW_SW;
         req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
         for (int i = 0; i < 1024; i++) mmem[d][i] = 8'h00;
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      for (int d = 0; d < 3; d++) reset[d] = 1'b0;
      @(negedge clock);
      test_reset();
      test_word();
      test_extension();
      test_errors();
      test_protect();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
